my_mult_core: RTL and testbench
===============================

Name: my_mult_core

Overview:
- Sequential radix-2 shift-add multiplier. Sits directly downstream of the my_mult_ip AXI4-Lite slave register file.
- Consumes operand A (slv_reg0) and operand B (slv_reg1) through a valid/ready handshake.
- Returns the 2×DATA_WIDTH product and a completed-operation counter for the read-back registers (slv_reg2/slv_reg3 and status).
- Fixed latency; one operation in flight.

Parameters:
- DATA_WIDTH, 32, operand width in bits (≥2); the product is 2*DATA_WIDTH.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- S_AXI_ACLK  in  1  clock; all logic on the rising edge.
- S_AXI_ARESETN  in  1  synchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  core can accept operands.
- op_a  in  DATA_WIDTH  multiplicand.
- op_b  in  DATA_WIDTH  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- result  out  2*DATA_WIDTH  product.
- busy  out  1  high in CALC or DONE.
- op_count  out  CNT_WIDTH  number of completed output handshakes; wraps.

Behaviour:
- Reset (S_AXI_ARESETN low at a rising edge):
  - state=IDLE; in_ready=1 after reset; out_valid=0, busy=0.
  - result=0, op_count=0.
  - Internal accumulator, shifters, bit counter and sign cleared.
  - Reset wins over every other event, including mid-CALC or mid-DONE. The in-flight operation is discarded and not counted.
- States: IDLE, CALC, DONE. in_ready = (state==IDLE), combinational from state. busy = (state!=IDLE).
- IDLE:
  - On in_valid && in_ready, latch: a_sh (2W bits) = zero-extended op_a; b_sh = op_b; acc=0; bit_cnt=0.
  - Then go to CALC.
  - No handshake: stay in IDLE.
- CALC, one bit per cycle:
  - If b_sh[0], acc <= acc + a_sh (modulo 2^(2W); cannot overflow for unsigned).
  - a_sh <= a_sh<<1; b_sh <= b_sh>>1; bit_cnt++.
  - When bit_cnt==DATA_WIDTH-1, the edge writes the final acc to result and goes to DONE.
  - No early termination; latency does not depend on the data.
- Latency: the handshake edge is edge 0, and out_valid is high after edge DATA_WIDTH, i.e. 32 cycles for the default.
- DONE:
  - out_valid=1; result held stable while out_valid && !out_ready (AXI-style hold).
  - On out_ready: out_valid drops at that edge, op_count++ (wraps 2^CNT_WIDTH-1 → 0), go to IDLE.
  - result keeps its last value until the next operation's final CALC edge.
- in_valid while busy is ignored; nothing is latched and no state changes.
- Back-to-back: the earliest next accept is the cycle after the output handshake (in_ready=1 in IDLE). Throughput is one operation per DATA_WIDTH+2 cycles with out_ready tied high.
- out_ready asserted outside DONE: no effect.
- Operands are sampled only at the accept edge; changes to op_a/op_b during CALC have no effect.

Optional Feature:
- Macro: MY_MULT_SIGNED_EN.
- When defined, operands are two's complement:
  - At accept, the core stores |op_a|, |op_b| (|−2^(W−1)| = 2^(W−1) fits unsigned) and neg = op_a[W−1]^op_b[W−1].
  - The final CALC edge writes neg ? −acc : acc (2W-bit two's complement) to result.
  - Latency unchanged.
  - Zero product is always 0, never negative zero.
- When not defined: unsigned-only; no sign logic is synthesized.

Test Plan:
1. Reset, then op_a=3, op_b=5 with out_ready=1 → in_ready drops the next cycle; out_valid rises exactly 32 cycles after accept; result=0x0000000000000F; op_count=1.
2. op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → result=0xFFFFFFFE00000001. Also op_a=0, op_b=0x12345678 → result=0 after 32 cycles.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, result stable, in_ready=0, op_count unchanged. Raise out_ready → op_count increments once; IDLE the next cycle.
4. Pulse in_valid with op_a=9, op_b=9 during CALC of 2×4 → ignored; result=8 and only one completion is counted.
5. Drive S_AXI_ARESETN low for 1 cycle at CALC cycle 10 of 0x1000×0x1000 → after reset out_valid=0, result=0, op_count=0, in_ready=1. Then 7×6 → result=42 at +32 cycles.
6. With MY_MULT_SIGNED_EN:
   - −3×5 → 0xFFFFFFFFFFFFFFF1.
   - 0x80000000×0x80000000 → 0x4000000000000000.
   - 0x80000000×1 → 0xFFFFFFFF80000000.
   - Latency 32 cycles in all cases.

Source files
------------

// File: rtl/my_mult_core.sv
// rtl/my_mult_core.sv - sequential radix-2 shift-add multiplier core
//
// Purpose: multiplies op_a by op_b one multiplier bit per cycle. The
// latency is fixed, and only one operation is in flight at a time. The
// product is held on result until the consumer accepts it.
//
// Ports:
//   S_AXI_ACLK     clock, rising edge
//   S_AXI_ARESETN  synchronous active-low reset
//   in_valid       operand handshake from the register file
//   in_ready       operand handshake from the register file
//   op_a           multiplicand
//   op_b           multiplier
//   out_valid      product handshake to the read-back logic
//   out_ready      product handshake to the read-back logic
//   result         2*DATA_WIDTH product
//   busy           high while an operation is in CALC or DONE
//   op_count       completed output handshakes, wraps
//
// Build option: define MY_MULT_SIGNED_EN for two's complement operands.
// In that build the core multiplies magnitudes and negates the product
// on the final CALC edge.

module my_mult_core #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   result,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      op_count
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic [PW-1:0]         a_sh;
  logic [PW-1:0]         acc;
  logic [PW-1:0]         acc_next;
  logic [PW-1:0]         final_val;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic [BW-1:0]         bit_cnt;
  logic                  last_bit;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // Partial sum including the current multiplier bit. On the last CALC
  // edge this is the complete product, so it feeds result directly.
  assign acc_next = b_sh[0] ? (acc + a_sh) : acc;
  assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

`ifdef MY_MULT_SIGNED_EN
  logic neg;
  logic neg_in;

  // The magnitude of the most negative value is 2^(W-1). It still fits
  // in W unsigned bits, so no widening is needed here.
  assign a_mag     = op_a[DATA_WIDTH-1] ? -op_a : op_a;
  assign b_mag     = op_b[DATA_WIDTH-1] ? -op_b : op_b;
  assign neg_in    = op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1];
  // Negating a zero magnitude gives zero, so a zero product never
  // comes out with a sign.
  assign final_val = neg ? -acc_next : acc_next;
`else
  assign a_mag     = op_a;
  assign b_mag     = op_b;
  assign final_val = acc_next;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
      result   <= '0;
      op_count <= '0;
`ifdef MY_MULT_SIGNED_EN
      neg      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= PW'(a_mag);
            b_sh    <= b_mag;
            acc     <= '0;
            bit_cnt <= '0;
`ifdef MY_MULT_SIGNED_EN
            neg     <= neg_in;
`endif
            state   <= CALC;
          end
        end
        CALC: begin
          acc     <= acc_next;
          a_sh    <= a_sh << 1;
          b_sh    <= b_sh >> 1;
          bit_cnt <= bit_cnt + BW'(1);
          if (last_bit) begin
            result <= final_val;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            op_count <= op_count + CNT_WIDTH'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_my_mult_core.sv
// tb/tb_my_mult_core.sv - self-checking bench for my_mult_core

module tb_my_mult_core;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] result;
  logic          busy;
  logic [CW-1:0] op_count;

  int n_checks;
  int n_pass;
  int exp_count;

  my_mult_core #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .busy          (busy),
    .op_count      (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference product from plain integer arithmetic on the operands.
  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MY_MULT_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    logic [63:0] ua;
    logic [63:0] ub;
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
`endif
  endfunction

  // One complete operation. The bench holds out_ready low for 'hold'
  // cycles in DONE. With glitch set, it pulses in_valid with other
  // operands during CALC.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit glitch,
                        output logic [63:0] res);
    int lat;
    int w;
    logic [63:0] held;
    out_ready = (hold == 0);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_drop", 64'(in_ready), 64'd0);
    check("busy_calc", 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (glitch && lat == 4) begin
        op_a = 9;
        op_b = 9;
        in_valid = 1'b1;
      end else if (glitch && lat == 5) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'd32);
    res = result;
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", result, held);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_count", 64'(op_count), 64'(exp_count));
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp_count = (exp_count + 1) % (1 << CW);
    check("done_valid_drop", 64'(out_valid), 64'd0);
    check("done_idle", 64'(in_ready), 64'd1);
    check("done_count", 64'(op_count), 64'(exp_count));
    check("result_kept", result, held);
  endtask

  initial begin
    logic [63:0] res;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_checks = 0;
    n_pass = 0;
    exp_count = 0;
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op_a = '0;
    op_b = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_count", 64'(op_count), 64'd0);

`ifdef MY_MULT_SIGNED_EN
    vecs.push_back('{32'hFFFFFFFD, 32'd5, 64'hFFFFFFFFFFFFFFF1});
    vecs.push_back('{32'h80000000, 32'h80000000, 64'h4000000000000000});
    vecs.push_back('{32'h80000000, 32'd1, 64'hFFFFFFFF80000000});
    vecs.push_back('{32'hFFFFFFF9, 32'd0, 64'd0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1});
`else
    vecs.push_back('{32'd3, 32'd5, 64'h000000000000000F});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001});
    vecs.push_back('{32'h80000000, 32'd2, 64'h0000000100000000});
`endif
    vecs.push_back('{32'd0, 32'h12345678, 64'd0});
    vecs.push_back('{32'd7, 32'd6, 64'd42});

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 0, 1'b0, res);
      check($sformatf("vec%0d", i), res, vecs[i].exp);
    end

    // Backpressure in DONE for ten cycles.
    run_op(32'd11, 32'd13, 10, 1'b0, res);
    check("bp_result", res, 64'd143);

    // in_valid pulse during CALC must be ignored.
    run_op(32'd2, 32'd4, 0, 1'b1, res);
    check("glitch_result", res, 64'd8);
    repeat (3) @(negedge clk);
    check("glitch_no_extra_op", 64'(busy), 64'd0);
    check("glitch_count", 64'(op_count), 64'(exp_count));

    // Reset in the middle of CALC discards the operation.
    op_a = 32'h1000;
    op_b = 32'h1000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_count = 0;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_count", 64'(op_count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    check("mid_rst_stays_idle", 64'(out_valid | busy), 64'd0);
    run_op(32'd7, 32'd6, 0, 1'b0, res);
    check("post_rst_result", res, 64'd42);

    // Randomised operands against the reference model; the run crosses
    // the op_count wrap.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'd0;
        default: ;
      endcase
      run_op(ra, rb, $urandom_range(0, 2), 1'b0, res);
      check($sformatf("rand%0d", i), res, model(ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
